// File: rtl/rf_wport_arbiter.sv
// Arbitrates the register-file write port between the in-order writeback path
// and buffered long-latency completions, with a starvation timer that stalls WB.
module rf_wport_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pl_wena,
  input  logic [5:0]               pl_addr,
  input  logic [31:0]              pl_data,
  output logic                     pl_stall,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [5:0]               lu_addr,
  input  logic [31:0]              lu_data,
  output logic                     rf_wena,
  output logic [5:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(MAX_WAIT);

  logic [5:0]    mem_addr_q [DEPTH];
  logic [31:0]   mem_data_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          rf_wena_q, rf_wena_d;
  logic [5:0]    rf_waddr_q, rf_waddr_d;
  logic [31:0]   rf_wdata_q, rf_wdata_d;
  logic          busy_w, force_w, pl_grant, pop, push;

  always_comb begin
    busy_w   = (count_q != '0);
    force_w  = busy_w && (wait_q >= WMAX);
    // x0 pipeline writes are dropped, so they leave the slot free for the FIFO
    pl_grant = !force_w && pl_wena && (pl_addr != 6'd0);
    pop      = force_w || (busy_w && !pl_grant);
    lu_ready = (count_q < FULL);
    push     = lu_valid && lu_ready && (lu_addr != 6'd0);
    pl_stall = force_w && pl_wena;
    count_d  = count_q + CW'(push) - CW'(pop);

    wait_d = wait_q;
    if (pop || !busy_w)     wait_d = '0;
    else if (wait_q < WMAX) wait_d = wait_q + WW'(1);

    rf_wena_d  = pl_grant || pop;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pop) begin
      rf_waddr_d = mem_addr_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
    end else if (pl_grant) begin
      rf_waddr_d = pl_addr;
      rf_wdata_d = pl_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      wait_q     <= '0;
      rf_wena_q  <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      wait_q     <= wait_d;
      rf_wena_q  <= rf_wena_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= lu_addr;
      mem_data_q[wr_ptr_q] <= lu_data;
    end
  end

  assign rf_wena    = rf_wena_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign fifo_count = count_q;
  assign busy       = busy_w;

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Self-checking bench for rf_wport_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_rf_wport_arbiter;
  localparam int DEPTH = 2;
  localparam int MAX_WAIT = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic reset;
  logic pl_wena, pl_stall, lu_valid, lu_ready, rf_wena, busy;
  logic [5:0] pl_addr, lu_addr, rf_waddr;
  logic [31:0] pl_data, lu_data, rf_wdata;
  logic [CW-1:0] fifo_count;

  rf_wport_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .pl_wena(pl_wena), .pl_addr(pl_addr), .pl_data(pl_data), .pl_stall(pl_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
    .rf_wena(rf_wena), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model state
  logic [5:0]  qa[$];
  logic [31:0] qd[$];
  int          m_wait = 0;
  logic        m_ready, m_force, m_stall, obs_ready, obs_stall;
  logic        e_wena = 1'b0;
  logic [5:0]  e_waddr = '0;
  logic [31:0] e_wdata = '0;

  task automatic idle_in();
    pl_wena = 0; pl_addr = '0; pl_data = '0;
    lu_valid = 0; lu_addr = '0; lu_data = '0;
  endtask

  // One clock of model + DUT; inputs are set by the caller beforehand.
  task automatic tick();
    int n;
    logic pop, we;
    logic [5:0] wa;
    logic [31:0] wd;
    n = qa.size();
    m_ready = (n < DEPTH);
    m_force = (n != 0) && (m_wait >= MAX_WAIT);
    m_stall = m_force && pl_wena;
    #1;
    obs_ready = lu_ready;
    obs_stall = pl_stall;
    pop = 0; we = 0; wa = '0; wd = '0;
    if (m_force) pop = 1;
    else if (pl_wena && pl_addr != 0) begin we = 1; wa = pl_addr; wd = pl_data; end
    else if (n != 0) pop = 1;
    if (pop) begin we = 1; wa = qa.pop_front(); wd = qd.pop_front(); end
    if (lu_valid && m_ready && lu_addr != 0) begin qa.push_back(lu_addr); qd.push_back(lu_data); end
    if (pop || n == 0) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait = m_wait + 1;
    @(posedge clk); #1;
    e_wena = we;
    if (we) begin e_waddr = wa; e_wdata = wd; end
  endtask

  task automatic drain();
    idle_in();
    repeat (DEPTH + MAX_WAIT + 2) tick();
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    nvec++; if (rf_wena !== 1'b0) begin nerr++; $display("FAIL rst_wena got %0b exp 0", rf_wena); end
    nvec++; if (rf_waddr !== 6'd0) begin nerr++; $display("FAIL rst_waddr got %0d exp 0", rf_waddr); end
    nvec++; if (rf_wdata !== 32'd0) begin nerr++; $display("FAIL rst_wdata got %0h exp 0", rf_wdata); end
    nvec++; if (fifo_count !== '0) begin nerr++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %0b exp 0", busy); end
    nvec++; if (pl_stall !== 1'b0) begin nerr++; $display("FAIL rst_stall got %0b exp 0", pl_stall); end
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      nvec++; if (obs_ready !== 1'b1) begin nerr++; $display("FAIL idle_ready c%0d got %0b exp 1", i, obs_ready); end
      nvec++; if (obs_stall !== 1'b0) begin nerr++; $display("FAIL idle_stall c%0d got %0b exp 0", i, obs_stall); end
      nvec++; if (rf_wena !== 1'b0) begin nerr++; $display("FAIL idle_wena c%0d got %0b exp 0", i, rf_wena); end
      nvec++; if (fifo_count !== '0) begin nerr++; $display("FAIL idle_count c%0d got %0d exp 0", i, fifo_count); end
    end
  endtask

  task automatic test_pipe_write();
    pl_wena = 1; pl_addr = 6'd5; pl_data = 32'hDEADBEEF;
    tick();
    idle_in();
    nvec++; if (rf_wena !== 1'b1) begin nerr++; $display("FAIL pipe_wena got %0b exp 1", rf_wena); end
    nvec++; if (rf_waddr !== 6'd5) begin nerr++; $display("FAIL pipe_waddr got %0d exp 5", rf_waddr); end
    nvec++; if (rf_wdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL pipe_wdata got %0h exp deadbeef", rf_wdata); end
    tick();
    nvec++; if (rf_wena !== 1'b0) begin nerr++; $display("FAIL pipe_wena_off got %0b exp 0", rf_wena); end
  endtask

  task automatic test_lu_write();
    lu_valid = 1; lu_addr = 6'd33; lu_data = 32'h3F800000;
    tick();
    idle_in();
    nvec++; if (obs_ready !== 1'b1) begin nerr++; $display("FAIL lu_ready got %0b exp 1", obs_ready); end
    nvec++; if (fifo_count !== 2'd1) begin nerr++; $display("FAIL lu_count1 got %0d exp 1", fifo_count); end
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL lu_busy got %0b exp 1", busy); end
    nvec++; if (rf_wena !== 1'b0) begin nerr++; $display("FAIL lu_nobypass got %0b exp 0", rf_wena); end
    tick();
    nvec++; if (rf_wena !== 1'b1) begin nerr++; $display("FAIL lu_wena got %0b exp 1", rf_wena); end
    nvec++; if (rf_waddr !== 6'd33) begin nerr++; $display("FAIL lu_waddr got %0d exp 33", rf_waddr); end
    nvec++; if (rf_wdata !== 32'h3F800000) begin nerr++; $display("FAIL lu_wdata got %0h exp 3f800000", rf_wdata); end
    nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL lu_count0 got %0d exp 0", fifo_count); end
  endtask

  task automatic test_starvation();
    pl_wena = 1; pl_addr = 6'd7; pl_data = 32'h7777_0007;
    lu_valid = 1; lu_addr = 6'd9; lu_data = 32'h9999_0009;
    for (int i = 0; i < 8; i++) begin
      tick();
      lu_valid = 0;
      nvec++; if (obs_stall !== (i == 5)) begin nerr++; $display("FAIL starve_stall c%0d got %0b exp %0b", i, obs_stall, (i == 5)); end
      nvec++; if (obs_stall !== m_stall) begin nerr++; $display("FAIL starve_stall_model c%0d got %0b exp %0b", i, obs_stall, m_stall); end
      nvec++; if (rf_wena !== 1'b1) begin nerr++; $display("FAIL starve_wena c%0d got %0b exp 1", i, rf_wena); end
      nvec++; if (rf_waddr !== ((i == 5) ? 6'd9 : 6'd7)) begin nerr++; $display("FAIL starve_waddr c%0d got %0d exp %0d", i, rf_waddr, (i == 5) ? 9 : 7); end
      nvec++; if (rf_wdata !== ((i == 5) ? 32'h9999_0009 : 32'h7777_0007)) begin nerr++; $display("FAIL starve_wdata c%0d got %0h", i, rf_wdata); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    pl_wena = 1; pl_addr = 6'd7; pl_data = 32'h7777_0007;
    lu_valid = 1; lu_addr = 6'd10; lu_data = 32'hA000_0010;
    for (int i = 0; i < 11; i++) begin
      tick();
      if (lu_valid && obs_ready) k++;
      lu_valid = (k < 3);
      lu_addr = 6'(10 + k); lu_data = 32'hA000_0010 + k;
      nvec++; if (obs_ready !== ((i < 2) || (i == 6))) begin nerr++; $display("FAIL b2b_ready c%0d got %0b exp %0b", i, obs_ready, ((i < 2) || (i == 6))); end
      nvec++; if (fifo_count !== CW'(qa.size())) begin nerr++; $display("FAIL b2b_count c%0d got %0d exp %0d", i, fifo_count, qa.size()); end
      nvec++; if (rf_wena !== e_wena || (e_wena && rf_waddr !== e_waddr)) begin nerr++; $display("FAIL b2b_write c%0d got %0b/%0d exp %0b/%0d", i, rf_wena, rf_waddr, e_wena, e_waddr); end
      if (i == 5) begin
        nvec++; if (k !== 2) begin nerr++; $display("FAIL b2b_third_early got %0d accepted exp 2", k); end
      end
    end
    nvec++; if (k !== 3) begin nerr++; $display("FAIL b2b_accepted got %0d exp 3", k); end
    drain();
  endtask

  task automatic test_zero_addr();
    lu_valid = 1; lu_addr = 6'd0; lu_data = 32'h0000_1234;
    tick();
    idle_in();
    nvec++; if (obs_ready !== 1'b1) begin nerr++; $display("FAIL x0_ready got %0b exp 1", obs_ready); end
    nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL x0_count got %0d exp 0", fifo_count); end
    tick();
    nvec++; if (rf_wena !== 1'b0) begin nerr++; $display("FAIL x0_wena got %0b exp 0", rf_wena); end
    lu_valid = 1; lu_addr = 6'd20; lu_data = 32'hCAFE_0020;
    tick();
    idle_in();
    pl_wena = 1; pl_addr = 6'd0; pl_data = 32'h5555_5555;
    tick();
    idle_in();
    nvec++; if (obs_stall !== 1'b0) begin nerr++; $display("FAIL plx0_stall got %0b exp 0", obs_stall); end
    nvec++; if (rf_wena !== 1'b1) begin nerr++; $display("FAIL plx0_wena got %0b exp 1", rf_wena); end
    nvec++; if (rf_waddr !== 6'd20) begin nerr++; $display("FAIL plx0_waddr got %0d exp 20", rf_waddr); end
    nvec++; if (rf_wdata !== 32'hCAFE_0020) begin nerr++; $display("FAIL plx0_wdata got %0h exp cafe0020", rf_wdata); end
    nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL plx0_count got %0d exp 0", fifo_count); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!m_stall) begin
        pl_wena = ($urandom_range(0, 3) != 0);
        pl_addr = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
        pl_data = $urandom;
      end
      lu_valid = ($urandom_range(0, 2) == 0);
      lu_addr = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom);
      lu_data = $urandom;
      tick();
      nvec++; if (obs_ready !== m_ready) begin nerr++; $display("FAIL rnd_ready c%0d got %0b exp %0b", i, obs_ready, m_ready); end
      nvec++; if (obs_stall !== m_stall) begin nerr++; $display("FAIL rnd_stall c%0d got %0b exp %0b", i, obs_stall, m_stall); end
      nvec++; if (rf_wena !== e_wena) begin nerr++; $display("FAIL rnd_wena c%0d got %0b exp %0b", i, rf_wena, e_wena); end
      if (e_wena) begin
        nvec++; if (rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin nerr++; $display("FAIL rnd_wdata c%0d got %0d:%0h exp %0d:%0h", i, rf_waddr, rf_wdata, e_waddr, e_wdata); end
      end
      nvec++; if (fifo_count !== CW'(qa.size()) || busy !== (qa.size() != 0)) begin nerr++; $display("FAIL rnd_count c%0d got %0d/%0b exp %0d", i, fifo_count, busy, qa.size()); end
    end
    drain();
  endtask

  task automatic test_async_reset();
    pl_wena = 1; pl_addr = 6'd7; pl_data = 32'h7777_0007;
    lu_valid = 1; lu_addr = 6'd40; lu_data = 32'h4000_0040;
    tick();
    lu_addr = 6'd41; lu_data = 32'h4100_0041;
    tick();
    lu_valid = 0;
    nvec++; if (fifo_count !== 2'd2) begin nerr++; $display("FAIL areset_pre_count got %0d exp 2", fifo_count); end
    #3 reset = 1;
    #1;
    nvec++; if (fifo_count !== 2'd0) begin nerr++; $display("FAIL areset_count got %0d exp 0", fifo_count); end
    nvec++; if (rf_wena !== 1'b0) begin nerr++; $display("FAIL areset_wena got %0b exp 0", rf_wena); end
    nvec++; if (busy !== 1'b0 || pl_stall !== 1'b0 || lu_ready !== 1'b1) begin nerr++; $display("FAIL areset_flags got busy %0b stall %0b ready %0b exp 0 0 1", busy, pl_stall, lu_ready); end
    qa.delete(); qd.delete(); m_wait = 0; e_wena = 0;
    @(posedge clk); #1;
    reset = 0;
    idle_in();
    for (int i = 0; i < 8; i++) begin
      tick();
      nvec++; if (rf_wena !== 1'b0 || fifo_count !== '0) begin nerr++; $display("FAIL areset_lost c%0d got wena %0b count %0d exp 0 0", i, rf_wena, fifo_count); end
    end
  endtask

  initial begin
    idle_in();
    reset = 1;
    test_reset();
    test_pipe_write();
    test_lu_write();
    test_starvation();
    test_back_to_back();
    test_zero_addr();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between two sources:
  - the in-order writeback path (the `rd_wena_to_WB` / `rd_addr_to_WB` / `rd_data_to_WB` group);
  - out-of-band completions from long-latency units (iterative divider, FPU div/sqrt).
- Long-latency results are buffered in a small FIFO and written in idle pipeline slots.
- A starvation timer forces a one-cycle pipeline stall so a buffered result cannot wait forever.
- Sits between the writeback stage and the integer/FP register file. Address bit 5 selects the FP bank.

Parameters:
- DEPTH, 2, number of buffered long-latency results (power of two, ≥2).
- MAX_WAIT, 4, cycles a FIFO head may wait before it preempts the pipeline (≥1).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pl_wena  input  1  pipeline writeback request this cycle
- pl_addr  input  6  pipeline destination register (bit 5 = FP bank)
- pl_data  input  32  pipeline write data
- pl_stall  output  1  pipeline write refused this cycle; WB must hold its inputs stable
- lu_valid  input  1  long-latency unit result valid
- lu_ready  output  1  arbiter can accept a long-latency result
- lu_addr  input  6  long-latency destination register
- lu_data  input  32  long-latency result data
- rf_wena  output  1  registered register-file write enable
- rf_waddr  output  6  registered register-file write address
- rf_wdata  output  32  registered register-file write data
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy
- busy  output  1  FIFO non-empty

Behaviour:
- Reset (async, active-high) clears:
  - FIFO pointers and count;
  - wait_cnt;
  - outputs rf_wena=0, rf_waddr=0, rf_wdata=0, fifo_count=0, busy=0, pl_stall=0.
- lu_ready is combinational and equals (count < DEPTH), using count before this cycle's pop.
  - A full FIFO does not accept in a cycle where it also pops.
- Enqueue occurs on lu_valid && lu_ready.
  - If lu_addr == 0 (integer x0), the handshake completes but nothing is stored.
- An entry enqueued in cycle N is eligible for grant from cycle N+1. There is no same-cycle bypass.
- wait_cnt:
  - increments, saturating at MAX_WAIT, each cycle the FIFO is non-empty and the head is not popped;
  - clears on pop and whenever the FIFO is empty.
- force = busy && (wait_cnt >= MAX_WAIT).
- Grant, evaluated combinationally each cycle, in priority order:
  1. force: pop the FIFO head. pl_stall = pl_wena.
  2. pl_wena && pl_addr != 0: pipeline granted. pl_stall = 0.
  3. pl_wena && pl_addr == 0: pipeline request dropped. The slot is treated as idle and the FIFO may pop. pl_stall = 0.
  4. busy: pop the FIFO head.
  5. else: no write.
- A stalled pipeline request is re-presented next cycle and must not be dropped. Force lasts exactly one cycle per pop, because wait_cnt clears on pop.
- Write latency: the granted write appears on rf_wena/rf_waddr/rf_wdata at the next clock edge (1 cycle). rf_wena=0 in cycles with no grant.
- fifo_count and busy are registered occupancy after enqueue/pop at each edge.
- Simultaneous enqueue and pop with count < DEPTH: count is unchanged and the pointers both advance.
- Pointers wrap modulo DEPTH.
- Ordering and WAW hazards between the two sources are prevented by the issue-stage scoreboard. The arbiter performs no address comparison.
- Reset asserted mid-operation discards all buffered results. Software-visible recovery is the trap/reset path's responsibility.

Test Plan:
- Reset, then idle → rf_wena=0, lu_ready=1, fifo_count=0, pl_stall=0 for 10 cycles.
- pl_wena=1, pl_addr=6'd5, pl_data=32'hDEADBEEF for one cycle → next cycle rf_wena=1, rf_waddr=5, rf_wdata=DEADBEEF; then rf_wena=0.
- lu_valid pulse with addr 6'd33, data 32'h3F800000, while pipeline idle → fifo_count=1 next cycle; rf_wena=1 with waddr=33 one cycle later; fifo_count returns to 0.
- Pipeline pl_wena=1 continuously (addr 7) and one lu result (addr 9):
  - pipeline writes for MAX_WAIT=4 cycles after the enqueue;
  - then pl_stall=1 for exactly one cycle and addr 9 is written;
  - pipeline resumes with the held addr 7 data, which is not lost.
- Three back-to-back lu_valid with continuous pipeline traffic, DEPTH=2:
  - lu_ready=0 after the second is accepted;
  - the third is accepted only after the first forced pop.
- lu_addr=0 accepted → fifo_count stays 0 and no rf write. pl_addr=0 with FIFO non-empty → FIFO head written that cycle.
- Assert reset asynchronously with fifo_count=2 → fifo_count=0, rf_wena=0, wait_cnt=0 immediately; the buffered entries are never written.
